// File: rtl/pc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pc_pkg : redirect-mode encodings and alignment helper           |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package pc_pkg;

  localparam logic [1:0] MODE_BRANCH = 2'b00;
  localparam logic [1:0] MODE_JUMP   = 2'b01;
  localparam logic [1:0] MODE_CALL   = 2'b10;
  localparam logic [1:0] MODE_RET    = 2'b11;

  // Number of low PC bits that must be zero for a given increment.
  function automatic int align_bits(input int inc);
    return (inc <= 1) ? 0 : $clog2(inc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_return_stack.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | return_stack : circular LIFO that overwrites its oldest entry   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module return_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              full
);

  localparam int             c_ptr_w = $clog2(RAS_DEPTH);
  localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(RAS_DEPTH);

  logic [ADDR_W-1:0]  r_mem [RAS_DEPTH];
  logic [c_ptr_w-1:0] r_top;
  logic [c_ptr_w:0]   r_count;
  logic [c_ptr_w-1:0] w_top_inc;

  assign w_top_inc = r_top + 1'b1;
  assign top_data  = r_mem[r_top];
  assign empty     = (r_count == '0);
  assign full      = (r_count == c_full_cnt);

  // A push into a full stack lands on the oldest slot because the pointer wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_mem[w_top_inc] <= push_data;
      r_top            <= w_top_inc;
      if (!full) r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_top   <= r_top - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pc_sequencer : registered PC with branch/jump/call/ret and RAS  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          INC       = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_mode,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_inc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              misalign_err,
  output logic              ras_underflow
);

  localparam int                c_align_w = align_bits(INC);
  localparam logic [ADDR_W-1:0] c_inc     = ADDR_W'(INC);

  logic [ADDR_W-1:0] r_pc;
  logic              r_misalign;
  logic              r_underflow;

  logic [ADDR_W-1:0] w_raw_next;
  logic [ADDR_W-1:0] w_aligned;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_check;
  logic              w_low_set;
  logic              w_push;
  logic              w_pop;
  logic              w_underflow;

  assign pc            = r_pc;
  assign pc_plus_inc   = r_pc + c_inc;
  assign misalign_err  = r_misalign;
  assign ras_underflow = r_underflow;

  always_comb begin
    w_raw_next  = r_pc + c_inc;
    w_check     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_underflow = 1'b0;
    if (redirect_valid) begin
      case (redirect_mode)
        MODE_BRANCH: begin
          w_raw_next = r_pc + target;
          w_check    = 1'b1;
        end
        MODE_JUMP: begin
          w_raw_next = target;
          w_check    = 1'b1;
        end
        MODE_CALL: begin
          w_raw_next = target;
          w_check    = 1'b1;
          w_push     = 1'b1;
        end
        default: begin
          // Popped addresses were pushed as pc+INC, so they need no check.
          if (!ras_empty) begin
            w_raw_next = w_ras_top;
            w_pop      = 1'b1;
          end else begin
            w_raw_next  = target;
            w_check     = 1'b1;
            w_underflow = 1'b1;
          end
        end
      endcase
    end
  end

  generate
    if (c_align_w > 0) begin : g_align
      assign w_low_set = |w_raw_next[c_align_w-1:0];
      assign w_aligned = {w_raw_next[ADDR_W-1:c_align_w], {c_align_w{1'b0}}};
    end else begin : g_no_align
      assign w_low_set = 1'b0;
      assign w_aligned = w_raw_next;
    end
  endgenerate

  assign w_next = w_check ? w_aligned : w_raw_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_misalign  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (stall) begin
      r_misalign  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_next;
      r_misalign  <= w_check & w_low_set;
      r_underflow <= w_underflow;
    end
  end

  return_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push & ~stall),
    .pop       (w_pop & ~stall),
    .push_data (pc_plus_inc),
    .top_data  (w_ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_pc_sequencer : directed + random bench with queue-based model|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_pc_sequencer;

  localparam int          ADDR_W    = 32;
  localparam int          INC       = 4;
  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [1:0]        redirect_mode = 2'b00;
  logic [ADDR_W-1:0] target = '0;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus_inc;
  logic              ras_empty;
  logic              ras_full;
  logic              misalign_err;
  logic              ras_underflow;

  pc_sequencer #(
    .ADDR_W    (ADDR_W),
    .INC       (INC),
    .RESET_PC  (RESET_PC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_mode  (redirect_mode),
    .target         (target),
    .pc             (pc),
    .pc_plus_inc    (pc_plus_inc),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full),
    .misalign_err   (misalign_err),
    .ras_underflow  (ras_underflow)
  );

  always #5 clk = ~clk;

  // Reference state: a plain queue stands in for the return stack.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_mis;
  logic        m_und;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_redirect(input logic [31:0] nxt);
    m_mis = (nxt % INC) != 0;
    m_pc  = nxt - (nxt % INC);
  endfunction

  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [1:0] md, input logic [31:0] tg);
    rst = r; stall = s; redirect_valid = rv; redirect_mode = md; target = tg;
    @(posedge clk);
    m_mis = 1'b0;
    m_und = 1'b0;
    if (r) begin
      m_pc = RESET_PC;
      m_ras.delete();
    end else if (s) begin
      // hold everything
    end else if (!rv) begin
      m_pc = m_pc + INC;
    end else begin
      case (md)
        2'b00: model_redirect(m_pc + tg);
        2'b01: model_redirect(tg);
        2'b10: begin
          m_ras.push_back(m_pc + INC);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
          model_redirect(tg);
        end
        default: begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else begin
            model_redirect(tg);
            m_und = 1'b1;
          end
        end
      endcase
    end
    #1;
    check("pc", pc, m_pc);
    check("pc_plus_inc", pc_plus_inc, m_pc + INC);
    check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    check("ras_full", 32'(ras_full), 32'(m_ras.size() == RAS_DEPTH));
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
    check("ras_underflow", 32'(ras_underflow), 32'(m_und));
  endtask

  task automatic idle();            step(0, 0, 0, 2'b00, 32'h0); endtask
  task automatic go(input logic [1:0] md, input logic [31:0] tg); step(0, 0, 1, md, tg); endtask

  initial begin
    m_pc = RESET_PC; m_mis = 0; m_und = 0;

    // Reset then sequential run
    step(1, 0, 0, 2'b00, 32'h0);
    check("reset_pc", pc, 32'h0);
    idle(); idle(); idle();
    check("seq_pc", pc, 32'hC);
    check("seq_link", pc_plus_inc, 32'h10);

    // Branch backward and wrap
    go(2'b01, 32'h20);
    go(2'b00, 32'hFFFF_FFF8);
    check("branch_back", pc, 32'h18);
    go(2'b01, 32'hFFFF_FFFC);
    idle();
    check("wrap_pc", pc, 32'h0);
    check("wrap_noflag", 32'(misalign_err), 32'h0);

    // Call / return
    go(2'b01, 32'h100);
    go(2'b10, 32'h400);
    idle(); idle();
    check("call_idle_pc", pc, 32'h408);
    go(2'b11, 32'h0);
    check("ret_pc", pc, 32'h104);

    // Overflow then underflow
    for (int i = 1; i <= 5; i++) begin
      go(2'b01, 32'(i * 16));
      go(2'b10, 32'h1000);
    end
    check("ovf_full", 32'(ras_full), 32'h1);
    for (int i = 0; i < 4; i++) begin
      go(2'b11, 32'h0);
      check("ovf_ret", pc, 32'h54 - 32'(i * 16));
    end
    go(2'b11, 32'h800);
    check("undf_pc", pc, 32'h800);
    check("undf_flag", 32'(ras_underflow), 32'h1);
    idle();
    check("undf_pulse", 32'(ras_underflow), 32'h0);

    // Stall and misalign
    step(0, 1, 1, 2'b01, 32'h200);
    check("stall_hold", pc, 32'h804);
    go(2'b01, 32'h202);
    check("mis_pc", pc, 32'h200);
    check("mis_flag", 32'(misalign_err), 32'h1);
    idle();
    check("mis_pulse", 32'(misalign_err), 32'h0);

    // Reset mid-operation
    go(2'b10, 32'h300);
    go(2'b10, 32'h500);
    step(1, 0, 0, 2'b00, 32'h0);
    check("rst_empty", 32'(ras_empty), 32'h1);
    go(2'b11, 32'h40);
    check("rst_ret_pc", pc, 32'h40);
    check("rst_ret_undf", 32'(ras_underflow), 32'h1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic        r, s, rv;
      logic [1:0]  md;
      logic [31:0] tg;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 1) == 1);
      md = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       tg = $urandom;
        1:       tg = 32'($signed($urandom_range(0, 255)) - 128);
        default: tg = $urandom & 32'hFFFF_FFFC;
      endcase
      step(r, s, rv, md, tg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
